lbp_stream: RTL and testbench

Parametrised local-binary-pattern engine: successor to the fixed 128×128 LBP block. It reads a grayscale frame of configurable size and pixel width from the gray memory port and writes one 8-bit LBP code per interior pixel to the LBP memory port. A 3×3 sliding-window register file reuses two columns between horizontally adjacent pixels, so only 3 reads are needed per pixel instead of 9. It adds a start/finish frame handshake for back-to-back frames and a run-time compare mode.

---
 rtl/lbp_pkg.sv | 34 +++
 rtl/lbp_window.sv | 49 ++++
 rtl/lbp_stream.sv | 161 ++++++++++++++++
 tb/tb_lbp_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming LBP engine.
package lbp_pkg;

    typedef enum logic [2:0] {IDLE, FILL, SHIFT, LAST, EMIT, DONE} state_t;

    // Code bit positions of the eight neighbours around the centre pixel
    localparam int B_NW = 0;
    localparam int B_N  = 1;
    localparam int B_NE = 2;
    localparam int B_W  = 3;
    localparam int B_E  = 4;
    localparam int B_SW = 5;
    localparam int B_S  = 6;
    localparam int B_SE = 7;

    localparam logic [3:0] FILL_LEN  = 4'd9;
    localparam logic [3:0] SHIFT_LEN = 4'd3;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } slot_t;

    // Column-major, top-to-bottom slot for read k of a 9-read fill
    function automatic slot_t fill_slot(input logic [3:0] k);
        slot_t s;
        if (k >= 4'd6)      s.col = 2'd2;
        else if (k >= 4'd3) s.col = 2'd1;
        else                s.col = 2'd0;
        s.row = 2'(k - 4'(s.col) * 4'd3);
        return s;
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window with slot load, left shift and combinational LBP code.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [1:0]        load_col,
    input  logic [1:0]        load_row,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              mode,
    output logic [7:0]        code
);

    // win[col][row]; col 0 is the left column, row 0 the top row
    logic [2:0][2:0][DATA_W-1:0] win;

    always_ff @(posedge clk) begin
        if (reset) begin
            win <= '0;
        end else begin
            if (shift) begin
                for (int c = 0; c < 2; c++) win[c] <= win[c+1];
            end
            if (load) win[load_col][load_row] <= load_data;
        end
    end

    function automatic logic cmp(input logic [DATA_W-1:0] nbr, input logic [DATA_W-1:0] ctr,
                                 input logic strict);
        return strict ? (nbr > ctr) : (nbr >= ctr);
    endfunction

    always_comb begin
        code       = '0;
        code[B_NW] = cmp(win[0][0], win[1][1], mode);
        code[B_N]  = cmp(win[1][0], win[1][1], mode);
        code[B_NE] = cmp(win[2][0], win[1][1], mode);
        code[B_W]  = cmp(win[0][1], win[1][1], mode);
        code[B_E]  = cmp(win[2][1], win[1][1], mode);
        code[B_SW] = cmp(win[0][2], win[1][1], mode);
        code[B_S]  = cmp(win[1][2], win[1][1], mode);
        code[B_SE] = cmp(win[2][2], win[1][1], mode);
    end

endmodule

// File: rtl/lbp_stream.sv
// Streaming LBP engine: sliding 3x3 window over a 2^W x 2^H gray frame, one code per interior pixel.
module lbp_stream
    import lbp_pkg::*;
#(
    parameter  int IMG_W_LOG2 = 7,
    parameter  int IMG_H_LOG2 = 7,
    parameter  int DATA_W     = 8,
    localparam int ADDR_W     = IMG_W_LOG2 + IMG_H_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam logic [IMG_W_LOG2-1:0] COL_LAST = IMG_W_LOG2'((1 << IMG_W_LOG2) - 2);
    localparam logic [IMG_H_LOG2-1:0] ROW_LAST = IMG_H_LOG2'((1 << IMG_H_LOG2) - 2);
    localparam logic [IMG_W_LOG2-1:0] COL_ONE  = IMG_W_LOG2'(1);
    localparam logic [IMG_H_LOG2-1:0] ROW_ONE  = IMG_H_LOG2'(1);

    state_t                 state, state_d;
    logic [IMG_H_LOG2-1:0]  row, row_d;
    logic [IMG_W_LOG2-1:0]  col, col_d;
    logic [3:0]             cnt, cnt_d;
    logic                   mode_q;
    logic                   accept, emit, shift_win, issue;
    slot_t                  slot_d;
    logic [IMG_H_LOG2-1:0]  rd_r;
    logic [IMG_W_LOG2-1:0]  rd_c;
    logic [1:0]             vld_pipe;   // [0] read issued, [1] read data present
    slot_t [1:0]            slot_pipe;
    logic [7:0]             code;

    assign gray_req = vld_pipe[0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        row_d     = row;
        col_d     = col;
        cnt_d     = cnt;
        accept    = 1'b0;
        emit      = 1'b0;
        shift_win = 1'b0;
        case (state)
            IDLE: if (start && gray_ready) begin
                accept  = 1'b1;
                row_d   = ROW_ONE;
                col_d   = COL_ONE;
                cnt_d   = '0;
                state_d = FILL;
            end
            FILL: if (cnt == FILL_LEN - 4'd1) begin
                cnt_d   = '0;
                state_d = LAST;
            end else begin
                cnt_d = cnt + 4'd1;
            end
            SHIFT: if (cnt == SHIFT_LEN - 4'd1) begin
                cnt_d   = '0;
                state_d = LAST;
            end else begin
                cnt_d = cnt + 4'd1;
            end
            LAST: state_d = EMIT;
            EMIT: begin
                emit  = 1'b1;
                cnt_d = '0;
                if (col < COL_LAST) begin
                    col_d     = col + COL_ONE;
                    shift_win = 1'b1;
                    state_d   = SHIFT;
                end else if (row < ROW_LAST) begin
                    row_d   = row + ROW_ONE;
                    col_d   = COL_ONE;
                    state_d = FILL;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address is built from next-cycle values so it is registered straight onto the port
    always_comb begin
        issue  = (state_d == FILL) || (state_d == SHIFT);
        slot_d = '0;
        if (state_d == FILL) begin
            slot_d = fill_slot(cnt_d);
        end else begin
            slot_d.col = 2'd2;
            slot_d.row = cnt_d[1:0];
        end
        rd_r = row_d + IMG_H_LOG2'(slot_d.row) - ROW_ONE;
        rd_c = col_d + IMG_W_LOG2'(slot_d.col) - COL_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            vld_pipe  <= '0;
            slot_pipe <= '0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
        end else begin
            row          <= row_d;
            col          <= col_d;
            cnt          <= cnt_d;
            vld_pipe     <= {vld_pipe[0], issue};
            slot_pipe[1] <= slot_pipe[0];
            if (issue) begin
                gray_addr    <= {rd_r, rd_c};
                slot_pipe[0] <= slot_d;
            end
            lbp_valid <= emit;
            if (emit) begin
                lbp_addr <= {row, col};
                lbp_data <= code;
            end
            if (accept) begin
                mode_q <= mode;
                finish <= 1'b0;
            end else if (state == DONE) begin
                finish <= 1'b1;
            end
        end
    end

    lbp_window #(.DATA_W(DATA_W)) u_window (
        .clk       (clk),
        .reset     (reset),
        .load      (vld_pipe[1]),
        .load_col  (slot_pipe[1].col),
        .load_row  (slot_pipe[1].row),
        .load_data (gray_data),
        .shift     (shift_win),
        .mode      (mode_q),
        .code      (code)
    );

endmodule

// File: tb/tb_lbp_stream.sv
// Randomized bench for lbp_stream on a 16x8, 10-bit frame against a neighbourhood reference model.
module tb_lbp_stream;

    localparam int WL        = 4;
    localparam int HL        = 3;
    localparam int DW        = 10;
    localparam int W         = 1 << WL;
    localparam int H         = 1 << HL;
    localparam int AW        = WL + HL;
    localparam int NPIX      = (W - 2) * (H - 2);
    localparam int FRAME_CYC = (H - 2) * (11 + (W - 3) * 5);

    logic          clk, reset, start, mode, gray_ready;
    logic          gray_req, lbp_valid, finish;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic [DW-1:0] gray_data;
    logic [7:0]    lbp_data;

    lbp_stream #(.IMG_W_LOG2(WL), .IMG_H_LOG2(HL), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    logic [DW-1:0] mem [W*H];
    int            got [W*H];
    int            DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int            DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int            n_vec = 0, n_err = 0;
    int            cyc = 0, acc_cyc = 0, last_cyc = 0, n_wr = 0, exp_r = 1, exp_c = 1;
    bit            cur_mode = 0;
    logic          prev_vld = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Gray memory: one-cycle read latency
    initial forever begin
        @(posedge clk);
        if (gray_req) gray_data <= mem[gray_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_code(int r, int c, bit m);
        int ctr, nb, code;
        code = 0;
        ctr  = int'(mem[r*W + c]);
        for (int i = 0; i < 8; i++) begin
            nb = int'(mem[(r + DR[i])*W + c + DC[i]]);
            if (m ? (nb > ctr) : (nb >= ctr)) code |= (1 << i);
        end
        return code;
    endfunction

    // Writes must arrive in raster order over the interior, never back to back
    initial forever begin
        @(negedge clk);
        if (lbp_valid) begin
            chk("vld_gap", int'(prev_vld), 0);
            if (exp_r <= H - 2) begin
                chk("wr_addr", int'(lbp_addr), exp_r*W + exp_c);
                chk("wr_code", int'(lbp_data), ref_code(exp_r, exp_c, cur_mode));
            end else begin
                chk("extra_write", int'(lbp_addr), -1);
            end
            got[lbp_addr] = int'(lbp_data);
            n_wr++;
            last_cyc = cyc;
            exp_c++;
            if (exp_c > W - 2) begin
                exp_c = 1;
                exp_r++;
            end
        end
        prev_vld = lbp_valid;
    end

    task automatic arm(input bit m);
        exp_r    = 1;
        exp_c    = 1;
        n_wr     = 0;
        cur_mode = m;
        for (int i = 0; i < W*H; i++) got[i] = -1;
        mode       = m;
        start      = 1;
        gray_ready = 1;
    endtask

    task automatic start_frame(input bit m, input bit hold);
        arm(m);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) start = 0;
    endtask

    task automatic wait_finish();
        int fin_cyc, bad;
        fin_cyc = -1;
        for (int i = 0; i < FRAME_CYC + 50; i++) begin
            @(negedge clk);
            if (finish) begin
                fin_cyc = cyc;
                break;
            end
        end
        if (fin_cyc < 0) chk("finish_timeout", 0, 1);
        else             chk("finish_lag", fin_cyc - last_cyc, 1);
        chk("writes", n_wr, NPIX);
        chk("frame_len", last_cyc - acc_cyc, FRAME_CYC);
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if ((r == 0 || r == H-1 || c == 0 || c == W-1) && got[r*W + c] != -1) bad++;
        chk("border_writes", bad, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   int'(gray_req),  0);
        chk({tag, "_gaddr"}, int'(gray_addr), 0);
        chk({tag, "_vld"},   int'(lbp_valid), 0);
        chk({tag, "_laddr"}, int'(lbp_addr),  0);
        chk({tag, "_ldata"}, int'(lbp_data),  0);
        chk({tag, "_fin"},   int'(finish),    0);
    endtask

    task automatic fill_flat(input int v);
        for (int i = 0; i < W*H; i++) mem[i] = DW'(v);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < W*H; i++) mem[i] = DW'($urandom_range(hi, lo));
    endtask

    initial begin
        reset = 1; start = 0; mode = 0; gray_ready = 0;
        fill_flat(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 0;

        // Flat frame: equal neighbours set every bit for >=, none for >
        fill_flat('h55);
        start_frame(0, 0); wait_finish();
        chk("flat0_11", got[1*W + 1], 'hFF);
        chk("flat0_last", got[(H-2)*W + W-2], 'hFF);
        start_frame(1, 0); wait_finish();
        chk("flat1_11", got[1*W + 1], 'h00);
        chk("flat1_last", got[(H-2)*W + W-2], 'h00);

        fill_flat('h10);
        mem[5*W + 5] = 'hFF;
        start_frame(1, 0); wait_finish();
        chk("spike1_55", got[5*W + 5], 'h00);
        chk("spike1_44", got[4*W + 4], 'h80);
        chk("spike1_66", got[6*W + 6], 'h01);
        chk("spike1_54", got[5*W + 4], 'h10);
        start_frame(0, 0); wait_finish();
        chk("spike0_55", got[5*W + 5], 'h00);
        chk("spike0_44", got[4*W + 4], 'hFF);

        fill_rand(0, (1 << DW) - 1);
        start_frame(0, 0); wait_finish();
        fill_rand(0, (1 << DW) - 1);
        start_frame(1, 0); wait_finish();
        fill_rand((1 << DW) - 16, (1 << DW) - 1);
        start_frame(0, 0); wait_finish();
        start_frame(1, 0); wait_finish();

        // start without gray_ready is not accepted; finish holds
        gray_ready = 0;
        start      = 1;
        repeat (6) begin
            @(negedge clk);
            chk("nrdy_req", int'(gray_req), 0);
            chk("nrdy_fin", int'(finish), 1);
        end
        start      = 0;
        gray_ready = 1;

        // start/mode/gray_ready wiggling mid-frame must not disturb it
        fill_rand(0, (1 << DW) - 1);
        start_frame(0, 0);
        repeat (100) @(negedge clk);
        start = 1; mode = 1; gray_ready = 0;
        repeat (4) @(negedge clk);
        start = 0; mode = 0; gray_ready = 1;
        wait_finish();

        // Abort on the 50th write, then a clean restart
        fill_rand(0, (1 << DW) - 1);
        start_frame(0, 0);
        for (int i = 0; i < FRAME_CYC && n_wr < 50; i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_reached", n_wr, 50);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("abort");
        repeat (3) @(negedge clk);
        reset = 0;
        chk("abort_writes", n_wr, 50);
        fill_rand(0, (1 << DW) - 1);
        start_frame(1, 0); wait_finish();

        // Back-to-back with start held: accept on the cycle finish is seen
        fill_rand(0, (1 << DW) - 1);
        start_frame(0, 1); wait_finish();
        arm(1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        chk("b2b_req", int'(gray_req), 1);
        chk("b2b_fin", int'(finish), 0);
        start = 0;
        wait_finish();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
